wb_write_arbiter: RTL and testbench

- Writeback stage directly upstream of the register file. Merges two result sources into the file's single write port (regWrite/regd/dataWrite).
  - Source 1: the single-cycle ALU retire port, which is never stalled.
  - Source 2: the long-latency multiply/divide unit (MDU), which uses a valid/ready handshake.
- MDU results are buffered in a small FIFO and drained in cycles when the ALU does not write.
- Provides a combinational pending-write query so decode can stall on RAW/WAW hazards against buffered MDU results.

---
 rtl/wb_pkg.sv | 21 ++
 rtl/wb_write_arbiter_if.sv | 49 ++++
 rtl/wb_fifo.sv | 84 ++++++++
 rtl/wb_write_arbiter.sv | 100 ++++++++++
 tb/tb_wb_write_arbiter.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
//  Package : wb_pkg
//  Shared constants and the buffered-result entry type for the writeback stage.
//  Revision: 1.0
// ============================================================================
package wb_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 32;

   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] rd;
      logic [DATA_W-1:0]     data;
   } wb_entry_t;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_write_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Interface : wb_write_arbiter_if
//  ALU/MDU result inputs, register-file write port and hazard query bundle.
//  Revision  : 1.0
// ============================================================================
interface wb_write_arbiter_if #(
   parameter int DEPTH      = 4,
   parameter int DATA_W     = wb_pkg::DATA_W,
   parameter int REG_ADDR_W = wb_pkg::REG_ADDR_W
);
   logic                    alu_wr_en;
   logic [REG_ADDR_W-1:0]   alu_wr_rd;
   logic [DATA_W-1:0]       alu_wr_data;
   logic                    mdu_valid;
   logic                    mdu_ready;
   logic [REG_ADDR_W-1:0]   mdu_rd;
   logic [DATA_W-1:0]       mdu_data;
   logic                    rf_we;
   logic [REG_ADDR_W-1:0]   rf_rd;
   logic [DATA_W-1:0]       rf_wdata;
   logic [REG_ADDR_W-1:0]   query_rs;
   logic [REG_ADDR_W-1:0]   query_rt;
   logic                    query_hit_rs;
   logic                    query_hit_rt;
   logic [$clog2(DEPTH):0]  fifo_count;

   modport slave (
      input  alu_wr_en, alu_wr_rd, alu_wr_data,
      input  mdu_valid, mdu_rd, mdu_data,
      output mdu_ready,
      output rf_we, rf_rd, rf_wdata,
      input  query_rs, query_rt,
      output query_hit_rs, query_hit_rt,
      output fifo_count
   );

   modport master (
      output alu_wr_en, alu_wr_rd, alu_wr_data,
      output mdu_valid, mdu_rd, mdu_data,
      input  mdu_ready,
      input  rf_we, rf_rd, rf_wdata,
      output query_rs, query_rt,
      input  query_hit_rs, query_hit_rt,
      input  fifo_count
   );

endinterface : wb_write_arbiter_if
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : wb_fifo
//  Result FIFO with per-entry kill by destination register and rd lookup.
//  Revision: 1.0
// ============================================================================
module wb_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  wire logic                  clk,
   input  wire logic                  reset,
   input  wire logic                  push,
   input  wire wb_entry_t             push_entry,
   input  wire logic                  pop,
   output wb_entry_t                  head,
   input  wire logic                  kill_en,
   input  wire logic [REG_ADDR_W-1:0] kill_rd,
   input  wire logic [REG_ADDR_W-1:0] match_a,
   input  wire logic [REG_ADDR_W-1:0] match_b,
   output logic                       hit_a,
   output logic                       hit_b,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;

   wb_entry_t          r_mem [DEPTH];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [IDX_W-1:0]   w_wr_idx;
   logic [IDX_W-1:0]   w_rd_idx;
   logic               w_do_push;
   logic               w_do_pop;

   assign w_wr_idx  = r_wr_ptr[IDX_W-1:0];
   assign w_rd_idx  = r_rd_ptr[IDX_W-1:0];
   assign full      = (r_wr_ptr[IDX_W] != r_rd_ptr[IDX_W]) && (w_wr_idx == w_rd_idx);
   assign empty     = (r_wr_ptr == r_rd_ptr);
   assign count     = r_wr_ptr - r_rd_ptr;
   assign head      = r_mem[w_rd_idx];
   assign w_do_push = push && !full;
   assign w_do_pop  = pop && !empty;

   // Popped slots drop their valid bit so the rd lookup only sees live entries.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (kill_en && (r_mem[i].rd == kill_rd)) begin
               r_mem[i].valid <= 1'b0;
            end
         end
         if (w_do_pop) begin
            r_mem[w_rd_idx].valid <= 1'b0;
            r_rd_ptr              <= r_rd_ptr + 1'b1;
         end
         if (w_do_push) begin
            r_mem[w_wr_idx] <= push_entry;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
      end
   end

   always_comb begin
      hit_a = 1'b0;
      hit_b = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_mem[i].valid && (r_mem[i].rd == match_a)) hit_a = 1'b1;
         if (r_mem[i].valid && (r_mem[i].rd == match_b)) hit_b = 1'b1;
      end
   end

endmodule : wb_fifo
`default_nettype wire

// File: rtl/wb_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : wb_write_arbiter
//  Merges ALU retire and buffered MDU results onto the register-file write port.
//  Revision: 1.0
// ============================================================================
module wb_write_arbiter #(
   parameter int DEPTH      = 4,
   parameter int DATA_W     = wb_pkg::DATA_W,
   parameter int REG_ADDR_W = wb_pkg::REG_ADDR_W
) (
   input  wire logic          clk,
   input  wire logic          reset,
   wb_write_arbiter_if.slave  bus
);

   import wb_pkg::wb_entry_t;
   import wb_pkg::REG_ZERO;

   wb_entry_t             w_push_entry;
   wb_entry_t             w_head;
   logic                  w_alu_wr;
   logic                  w_accept;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_fifo_hit_rs;
   logic                  w_fifo_hit_rt;
   logic                  r_rf_we;
   logic [REG_ADDR_W-1:0] r_rf_rd;
   logic [DATA_W-1:0]     r_rf_wdata;

   assign w_alu_wr      = bus.alu_wr_en && (bus.alu_wr_rd != REG_ZERO);
   assign bus.mdu_ready = !w_full && !reset;
   assign w_accept      = bus.mdu_valid && bus.mdu_ready;
   assign w_push        = w_accept && (bus.mdu_rd != REG_ZERO);
   assign w_pop         = !w_alu_wr && !w_empty;

   // A same-edge ALU write to the same rd is younger, so the MDU result lands dead.
   always_comb begin
      w_push_entry       = '0;
      w_push_entry.valid = !(w_alu_wr && (bus.mdu_rd == bus.alu_wr_rd));
      w_push_entry.rd    = bus.mdu_rd;
      w_push_entry.data  = bus.mdu_data;
   end

   wb_fifo #(
      .DEPTH      (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (w_push),
      .push_entry (w_push_entry),
      .pop        (w_pop),
      .head       (w_head),
      .kill_en    (w_alu_wr),
      .kill_rd    (bus.alu_wr_rd),
      .match_a    (bus.query_rs),
      .match_b    (bus.query_rt),
      .hit_a      (w_fifo_hit_rs),
      .hit_b      (w_fifo_hit_rt),
      .count      (bus.fifo_count),
      .full       (w_full),
      .empty      (w_empty)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rf_we    <= 1'b0;
         r_rf_rd    <= '0;
         r_rf_wdata <= '0;
      end else if (w_alu_wr) begin
         r_rf_we    <= 1'b1;
         r_rf_rd    <= bus.alu_wr_rd;
         r_rf_wdata <= bus.alu_wr_data;
      end else if (w_pop) begin
         r_rf_we    <= w_head.valid;
         r_rf_rd    <= w_head.rd;
         r_rf_wdata <= w_head.data;
      end else begin
         r_rf_we    <= 1'b0;
      end
   end

   assign bus.rf_we    = r_rf_we;
   assign bus.rf_rd    = r_rf_rd;
   assign bus.rf_wdata = r_rf_wdata;

   assign bus.query_hit_rs = (bus.query_rs != REG_ZERO) &&
                             (w_fifo_hit_rs ||
                              (w_accept && (bus.mdu_rd == bus.query_rs)) ||
                              (r_rf_we && (r_rf_rd == bus.query_rs)));
   assign bus.query_hit_rt = (bus.query_rt != REG_ZERO) &&
                             (w_fifo_hit_rt ||
                              (w_accept && (bus.mdu_rd == bus.query_rt)) ||
                              (r_rf_we && (r_rf_rd == bus.query_rt)));

endmodule : wb_write_arbiter
`default_nettype wire

// File: tb/tb_wb_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_wb_write_arbiter
//  Scoreboard bench for wb_write_arbiter: directed ALU/MDU vectors.
//  Revision: 1.0
// ============================================================================
module tb_wb_write_arbiter;
   import wb_pkg::*;

   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   wb_write_arbiter_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) bus();

   wb_write_arbiter #(
      .DEPTH      (DEPTH),
      .DATA_W     (DATA_W),
      .REG_ADDR_W (REG_ADDR_W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   logic [36:0] sb_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void expect_wr(input logic [4:0] rd, input logic [31:0] d);
      sb_q.push_back({rd, d});
   endfunction

   // Every register-file write must match the next expected write, in order.
   always @(negedge clk) begin
      if (reset === 1'b0 && bus.rf_we !== 1'b0) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: got rf_we=%b rd=%0d data=0x%0h, expected no write",
                     bus.rf_we, bus.rf_rd, bus.rf_wdata);
         end else begin
            chk("rf_write", {27'd0, bus.rf_rd, bus.rf_wdata}, {27'd0, sb_q.pop_front()});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_alu(input logic en, input logic [4:0] rd, input logic [31:0] d);
      bus.alu_wr_en   = en;
      bus.alu_wr_rd   = rd;
      bus.alu_wr_data = d;
   endtask

   task automatic set_mdu(input logic v, input logic [4:0] rd, input logic [31:0] d);
      bus.mdu_valid = v;
      bus.mdu_rd    = rd;
      bus.mdu_data  = d;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      set_alu(1'b0, 5'd0, 32'd0);
      set_mdu(1'b1, 5'd7, 32'h77);
      bus.query_rs = 5'd0;
      bus.query_rt = 5'd0;
      step();
      step();
      chk("reset_rf_we", bus.rf_we, 1'b0);
      chk("reset_count", bus.fifo_count, 3'd0);
      chk("reset_ready", bus.mdu_ready, 1'b0);
      set_mdu(1'b0, 5'd0, 32'd0);
      reset = 1'b0;
      step();

      // ALU write visible exactly one cycle later
      set_alu(1'b1, 5'd8, 32'h1);
      expect_wr(5'd8, 32'h1);
      step();
      chk("alu_latency_we", bus.rf_we, 1'b1);
      set_alu(1'b0, 5'd0, 32'd0);
      step();
      chk("alu_one_cycle", bus.rf_we, 1'b0);

      // MDU result with ALU idle: push edge then pop edge
      set_mdu(1'b1, 5'd3, 32'h594);
      bus.query_rs = 5'd3;
      expect_wr(5'd3, 32'h594);
      #1;
      chk("mdu_ready_idle", bus.mdu_ready, 1'b1);
      chk("hit_incoming", bus.query_hit_rs, 1'b1);
      step();
      set_mdu(1'b0, 5'd0, 32'd0);
      #1;
      chk("mdu_count1", bus.fifo_count, 3'd1);
      chk("hit_fifo", bus.query_hit_rs, 1'b1);
      chk("mdu_not_yet", bus.rf_we, 1'b0);
      step();
      chk("mdu_lat2_we", bus.rf_we, 1'b1);
      chk("hit_outstage", bus.query_hit_rs, 1'b1);
      step();
      chk("hit_cleared", bus.query_hit_rs, 1'b0);

      // Fill while the ALU writes every cycle, then drain in order
      for (int k = 0; k < 5; k++) expect_wr(5'(10 + k), 32'hA00 + k);
      for (int k = 0; k < 4; k++) expect_wr(5'(16 + k), 32'hB00 + k);
      for (int k = 0; k < 4; k++) begin
         set_alu(1'b1, 5'(10 + k), 32'hA00 + k);
         set_mdu(1'b1, 5'(16 + k), 32'hB00 + k);
         #1;
         chk("fill_ready", bus.mdu_ready, 1'b1);
         step();
      end
      chk("full_count", bus.fifo_count, 3'd4);
      set_alu(1'b1, 5'd14, 32'hA04);
      set_mdu(1'b1, 5'd20, 32'hBFF);
      #1;
      chk("full_ready", bus.mdu_ready, 1'b0);
      step();
      chk("full_hold", bus.fifo_count, 3'd4);
      set_alu(1'b0, 5'd0, 32'd0);
      #1;
      chk("no_bypass_ready", bus.mdu_ready, 1'b0);
      step();
      set_mdu(1'b0, 5'd0, 32'd0);
      chk("drain_count3", bus.fifo_count, 3'd3);
      for (int k = 2; k >= 0; k--) begin
         step();
         chk("drain_count", bus.fifo_count, 3'(k));
      end
      step();

      // WAW: buffered rd=4 superseded by a later ALU write
      expect_wr(5'd9, 32'h900);
      expect_wr(5'd4, 32'h200);
      set_alu(1'b1, 5'd9, 32'h900);
      set_mdu(1'b1, 5'd4, 32'h410);
      step();
      set_mdu(1'b0, 5'd0, 32'd0);
      set_alu(1'b1, 5'd4, 32'h200);
      bus.query_rs = 5'd4;
      chk("waw_count1", bus.fifo_count, 3'd1);
      step();
      set_alu(1'b0, 5'd0, 32'd0);
      #1;
      chk("waw_hit_out", bus.query_hit_rs, 1'b1);
      step();
      chk("waw_killed_pop", bus.rf_we, 1'b0);
      chk("waw_count0", bus.fifo_count, 3'd0);
      chk("waw_hit_gone", bus.query_hit_rs, 1'b0);

      // Same-edge kill: MDU push and ALU write to rd=5 together
      expect_wr(5'd5, 32'h555);
      set_alu(1'b1, 5'd5, 32'h555);
      set_mdu(1'b1, 5'd5, 32'h5AA);
      bus.query_rt = 5'd5;
      step();
      set_alu(1'b0, 5'd0, 32'd0);
      set_mdu(1'b0, 5'd0, 32'd0);
      #1;
      chk("same_edge_count", bus.fifo_count, 3'd1);
      chk("same_edge_hit_rt", bus.query_hit_rt, 1'b1);
      step();
      chk("same_edge_killed", bus.rf_we, 1'b0);
      chk("same_edge_hit_rt0", bus.query_hit_rt, 1'b0);

      // MDU result to r0: handshaken, never buffered or written
      set_mdu(1'b1, 5'd0, 32'hDEAD);
      #1;
      chk("r0_ready", bus.mdu_ready, 1'b1);
      step();
      set_mdu(1'b0, 5'd0, 32'd0);
      chk("r0_count", bus.fifo_count, 3'd0);
      step();
      chk("r0_no_write", bus.rf_we, 1'b0);

      // Wrap: 10 results stream through, pointers pass 2*DEPTH
      for (int k = 0; k < 3; k++) expect_wr(5'(25 + k), 32'hD00 + k);
      for (int i = 0; i < 10; i++) expect_wr(5'(1 + i), 32'hC00 + i);
      for (int i = 0; i < 10; i++) begin
         if (i < 3) set_alu(1'b1, 5'(25 + i), 32'hD00 + i);
         else       set_alu(1'b0, 5'd0, 32'd0);
         set_mdu(1'b1, 5'(1 + i), 32'hC00 + i);
         for (int t = 0; t < 20 && bus.mdu_ready !== 1'b1; t++) step();
         if (bus.mdu_ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL wrap_ready_timeout: got ready=%b, expected 1", bus.mdu_ready);
         end
         step();
         chk("wrap_count_le_depth", bus.fifo_count <= 3'd4, 1'b1);
      end
      set_alu(1'b0, 5'd0, 32'd0);
      set_mdu(1'b0, 5'd0, 32'd0);
      for (int t = 0; t < 12 && bus.fifo_count != 0; t++) step();
      chk("wrap_drained", bus.fifo_count, 3'd0);
      step();

      // Reset mid-drain with entries still buffered
      for (int k = 0; k < 3; k++) expect_wr(5'd12, 32'hE00 + k);
      expect_wr(5'd13, 32'hF00);
      for (int k = 0; k < 3; k++) begin
         set_alu(1'b1, 5'd12, 32'hE00 + k);
         set_mdu(1'b1, 5'(13 + k), 32'hF00 + k);
         step();
      end
      set_alu(1'b0, 5'd0, 32'd0);
      set_mdu(1'b0, 5'd0, 32'd0);
      chk("pre_reset_count", bus.fifo_count, 3'd3);
      step();
      @(negedge clk);
      #1;
      reset = 1'b1;
      set_mdu(1'b1, 5'd6, 32'h66);
      #1;
      chk("midreset_we", bus.rf_we, 1'b0);
      chk("midreset_count", bus.fifo_count, 3'd0);
      chk("midreset_ready", bus.mdu_ready, 1'b0);
      step();
      step();
      chk("reset_hold_ready", bus.mdu_ready, 1'b0);
      set_mdu(1'b0, 5'd0, 32'd0);
      reset = 1'b0;
      for (int t = 0; t < 4; t++) step();
      chk("post_reset_count", bus.fifo_count, 3'd0);
      chk("scoreboard_empty", sb_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_wb_write_arbiter
`default_nettype wire
